id_ex_stage: RTL and testbench

ID/EX pipeline register of the 5-stage RISC-V core, directly downstream of the register file. Captures the register-file read operands and the decoded instruction fields, detects load-use hazards, and inserts a one-cycle bubble when one occurs. Computes registered forwarding selects for the EX operand muxes. Keeps a saturating load-use stall counter for performance monitoring.

---
 rtl/core_pkg.sv | 19 +
 rtl/hazard_fwd_unit.sv | 46 ++++
 rtl/id_ex_stage.sv | 182 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: data width, register index width, forwarding
// select encoding and the ID/EX stage occupancy states.
package core_pkg;

   localparam int XLEN  = 32;
   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_st_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use hazard detection and forwarding-select computation
// for the instruction being decoded, relative to the entry held in ID/EX and
// the instruction currently in EX/MEM.
module hazard_fwd_unit
   import core_pkg::*;
(
   input  logic             held_valid_i,
   input  logic             held_mem_read_i,
   input  logic             held_reg_write_i,
   input  logic [REG_W-1:0] held_rd_i,
   input  logic [REG_W-1:0] in_rs1_i,
   input  logic [REG_W-1:0] in_rs2_i,
   input  logic             in_uses_rs1_i,
   input  logic             in_uses_rs2_i,
   input  logic [REG_W-1:0] exmem_rd_i,
   input  logic             exmem_reg_write_i,
   output logic             hazard_o,
   output fwd_sel_t         fwd_a_o,
   output fwd_sel_t         fwd_b_o
);

   // The held entry becomes EX/MEM once this instruction is captured, so it
   // is the nearest producer; the current EX/MEM entry will then be in MEM/WB.
   function automatic fwd_sel_t sel_for(input logic [REG_W-1:0] rs);
      fwd_sel_t s;
      s = FWD_RF;
      if (rs != '0) begin
         if (held_valid_i && held_reg_write_i && held_rd_i == rs)
            s = FWD_EXMEM;
         else if (exmem_reg_write_i && exmem_rd_i == rs)
            s = FWD_MEMWB;
      end
      return s;
   endfunction

   // Load data is not available until after MEM, so a consumer directly
   // behind a load must wait one cycle.
   always_comb begin
      hazard_o = held_valid_i && held_mem_read_i && (held_rd_i != '0) &&
                 ((in_uses_rs1_i && in_rs1_i == held_rd_i) ||
                  (in_uses_rs2_i && in_rs2_i == held_rd_i));
      fwd_a_o  = sel_for(in_rs1_i);
      fwd_b_o  = sel_for(in_rs2_i);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands and decoded fields, inserts a
// bubble on load-use hazards, registers EX forwarding selects and counts
// load-use stall cycles (saturating).
// Optional: define ID_WB_BYPASS_EN to bypass a same-cycle write-back into the
// captured operands for register files that write on the rising edge.
module id_ex_stage
   import core_pkg::*;
#(
   parameter int XLEN   = core_pkg::XLEN,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [REG_W-1:0]  in_rs1,
   input  logic [REG_W-1:0]  in_rs2,
   input  logic [REG_W-1:0]  in_rd,
   input  logic              in_uses_rs1,
   input  logic              in_uses_rs2,
   input  logic              in_reg_write,
   input  logic              in_mem_read,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [XLEN-1:0]   rf_data1,
   input  logic [XLEN-1:0]   rf_data2,
   input  logic [REG_W-1:0]  exmem_rd,
   input  logic              exmem_reg_write,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic              wb_reg_write,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_imm,
   output logic [XLEN-1:0]   out_op1,
   output logic [XLEN-1:0]   out_op2,
   output logic [REG_W-1:0]  out_rs1,
   output logic [REG_W-1:0]  out_rs2,
   output logic [REG_W-1:0]  out_rd,
   output logic              out_reg_write,
   output logic              out_mem_read,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        out_fwd_a,
   output logic [1:0]        out_fwd_b,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   op1;
      logic [XLEN-1:0]   op2;
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic [REG_W-1:0]  rd;
      logic              reg_write;
      logic              mem_read;
      logic [CTRL_W-1:0] ctrl;
      fwd_sel_t          fwd_a;
      fwd_sel_t          fwd_b;
   } payload_t;

   stage_st_t        state_q, state_d;
   payload_t         pay_q, pay_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             advance, hazard, capture;
   fwd_sel_t         fwd_a, fwd_b;
   logic [XLEN-1:0]  op1, op2;

   hazard_fwd_unit u_hfu (
      .held_valid_i      (out_valid),
      .held_mem_read_i   (pay_q.mem_read),
      .held_reg_write_i  (pay_q.reg_write),
      .held_rd_i         (pay_q.rd),
      .in_rs1_i          (in_rs1),
      .in_rs2_i          (in_rs2),
      .in_uses_rs1_i     (in_uses_rs1),
      .in_uses_rs2_i     (in_uses_rs2),
      .exmem_rd_i        (exmem_rd),
      .exmem_reg_write_i (exmem_reg_write),
      .hazard_o          (hazard),
      .fwd_a_o           (fwd_a),
      .fwd_b_o           (fwd_b)
   );

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && (!hazard || flush);
   assign capture  = in_valid && in_ready && !flush;

   // Operand selection: x0 reads as zero; optional write-back bypass only
   // where EX will not overwrite the operand through its own forwarding.
`ifdef ID_WB_BYPASS_EN
   always_comb begin
      op1 = rf_data1;
      op2 = rf_data2;
      if (fwd_a == FWD_RF && wb_reg_write && wb_rd != '0 && wb_rd == in_rs1)
         op1 = wb_data;
      if (fwd_b == FWD_RF && wb_reg_write && wb_rd != '0 && wb_rd == in_rs2)
         op2 = wb_data;
      if (in_rs1 == '0) op1 = '0;
      if (in_rs2 == '0) op2 = '0;
   end
`else
   logic wb_unused;
   assign wb_unused = ^{wb_rd, wb_reg_write, wb_data};

   always_comb begin
      op1 = (in_rs1 == '0) ? '0 : rf_data1;
      op2 = (in_rs2 == '0) ? '0 : rf_data2;
   end
`endif

   // State register; reset drops the held entry immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   // Next state: an advancing stage fills only on capture, otherwise empties
   // (bubble, flush or no input); a stalled stage holds.
   always_comb begin
      state_d = state_q;
      if (advance) state_d = capture ? ST_FULL : ST_EMPTY;
   end

   // Output decode of the occupancy state.
   always_comb begin
      out_valid = (state_q == ST_FULL);
   end

   // Payload and stall-counter next-state.
   always_comb begin
      pay_d = pay_q;
      if (capture) begin
         pay_d.pc        = in_pc;
         pay_d.imm       = in_imm;
         pay_d.op1       = op1;
         pay_d.op2       = op2;
         pay_d.rs1       = in_rs1;
         pay_d.rs2       = in_rs2;
         pay_d.rd        = in_rd;
         pay_d.reg_write = in_reg_write;
         pay_d.mem_read  = in_mem_read;
         pay_d.ctrl      = in_ctrl;
         pay_d.fwd_a     = fwd_a;
         pay_d.fwd_b     = fwd_b;
      end
      cnt_d = cnt_q;
      if (hazard && in_valid && advance && !flush && cnt_q != '1)
         cnt_d = cnt_q + 1'b1;
   end

   // Payload and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pay_q <= '0;
         cnt_q <= '0;
      end else begin
         pay_q <= pay_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_pc        = pay_q.pc;
   assign out_imm       = pay_q.imm;
   assign out_op1       = pay_q.op1;
   assign out_op2       = pay_q.op2;
   assign out_rs1       = pay_q.rs1;
   assign out_rs2       = pay_q.rs2;
   assign out_rd        = pay_q.rd;
   assign out_reg_write = pay_q.reg_write;
   assign out_mem_read  = pay_q.mem_read;
   assign out_ctrl      = pay_q.ctrl;
   assign out_fwd_a     = pay_q.fwd_a;
   assign out_fwd_b     = pay_q.fwd_b;
   assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table per cycle, then hand-written
// sequences for stall-counter saturation and asynchronous reset.
module tb_id_ex_stage;

   localparam int XLEN = 32;
   localparam int CW   = 16;
   localparam int NW   = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_ready;
   logic [XLEN-1:0] in_pc, in_imm;
   logic [4:0]      in_rs1, in_rs2, in_rd;
   logic            in_uses_rs1, in_uses_rs2, in_reg_write, in_mem_read;
   logic [CW-1:0]   in_ctrl;
   logic [XLEN-1:0] rf_data1, rf_data2;
   logic [4:0]      exmem_rd, wb_rd;
   logic            exmem_reg_write, wb_reg_write;
   logic [XLEN-1:0] wb_data;
   logic            flush, out_valid, out_ready;
   logic [XLEN-1:0] out_pc, out_imm, out_op1, out_op2;
   logic [4:0]      out_rs1, out_rs2, out_rd;
   logic            out_reg_write, out_mem_read;
   logic [CW-1:0]   out_ctrl;
   logic [1:0]      out_fwd_a, out_fwd_b;
   logic [NW-1:0]   stall_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CW), .CNT_W(NW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_imm(in_imm),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
      .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
      .in_ctrl(in_ctrl), .rf_data1(rf_data1), .rf_data2(rf_data2),
      .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm), .out_op1(out_op1), .out_op2(out_op2),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_ctrl(out_ctrl), .out_fwd_a(out_fwd_a), .out_fwd_b(out_fwd_b),
      .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic        vld;
      logic [4:0]  rs1, rs2, rd;
      logic        u1, u2, rw, mr;
      logic [31:0] rf1, rf2;
      logic [4:0]  xrd;
      logic        xrw, fl, ordy;
      logic        e_rdy, e_vld;
      logic [31:0] e_op1, e_op2;
      logic [1:0]  e_fa, e_fb;
      logic [4:0]  e_rd;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid     = v.vld;
      in_rs1       = v.rs1;
      in_rs2       = v.rs2;
      in_rd        = v.rd;
      in_uses_rs1  = v.u1;
      in_uses_rs2  = v.u2;
      in_reg_write = v.rw;
      in_mem_read  = v.mr;
      rf_data1     = v.rf1;
      rf_data2     = v.rf2;
      exmem_rd     = v.xrd;
      exmem_reg_write = v.xrw;
      flush        = v.fl;
      out_ready    = v.ordy;
      in_pc        = {27'd0, v.rd} << 2;
      in_imm       = 32'h100;
      in_ctrl      = {11'd0, v.rd};
   endtask

   logic [31:0] x7_exp;
   logic [3:0]  cnt_exp;
   vec_t        ld;

   initial begin
`ifdef ID_WB_BYPASS_EN
      x7_exp = 32'h0bad;
`else
      x7_exp = 32'h1234;
`endif
      //          vld rs1 rs2 rd u1 u2 rw mr rf1       rf2      xrd xrw fl ordy rdy vld op1       op2     fa fb rd cnt
      vecs[0]  = '{1, 1, 0, 5,  1, 0, 1, 0, 32'h10,   32'h0,   0, 0, 0, 1, 1, 1, 32'h10,  32'h0,  0, 0, 5,  0};
      vecs[1]  = '{1, 0, 7, 6,  1, 1, 1, 0, 32'hdead, 32'h1234,0, 0, 0, 1, 1, 1, 32'h0,   x7_exp, 0, 0, 6,  0};
      vecs[2]  = '{1, 1, 2, 5,  1, 1, 1, 0, 32'h1,    32'h2,   5, 1, 0, 1, 1, 1, 32'h1,   32'h2,  0, 0, 5,  0};
      vecs[3]  = '{1, 5, 5, 8,  1, 1, 1, 0, 32'h55,   32'h55,  6, 1, 0, 1, 1, 1, 32'h55,  32'h55, 1, 1, 8,  0};
      vecs[4]  = '{1, 5, 3, 9,  1, 1, 1, 0, 32'h66,   32'h33,  5, 1, 0, 1, 1, 1, 32'h66,  32'h33, 2, 0, 9,  0};
      vecs[5]  = '{1, 1, 0, 5,  1, 0, 1, 1, 32'h100,  32'h0,   8, 1, 0, 1, 1, 1, 32'h100, 32'h0,  0, 0, 5,  0};
      vecs[6]  = '{1, 5, 1, 6,  1, 1, 1, 0, 32'h77,   32'h100, 9, 1, 0, 1, 0, 0, 32'h0,   32'h0,  0, 0, 0,  1};
      vecs[7]  = '{1, 5, 1, 6,  1, 1, 1, 0, 32'h77,   32'h100, 5, 1, 0, 1, 1, 1, 32'h77,  32'h100,2, 0, 6,  1};
      vecs[8]  = '{1, 1, 2, 10, 1, 1, 1, 0, 32'h1,    32'h2,   6, 1, 1, 1, 1, 0, 32'h0,   32'h0,  0, 0, 0,  1};
      vecs[9]  = '{1, 3, 4, 11, 1, 1, 1, 0, 32'h3,    32'h4,   0, 0, 0, 1, 1, 1, 32'h3,   32'h4,  0, 0, 11, 1};
      vecs[10] = '{1, 11,0, 12, 1, 0, 1, 0, 32'hc,    32'h0,   0, 0, 0, 0, 0, 1, 32'h3,   32'h4,  0, 0, 11, 1};
      vecs[11] = '{1, 11,0, 12, 1, 0, 1, 0, 32'hc,    32'h0,   0, 0, 0, 0, 0, 1, 32'h3,   32'h4,  0, 0, 11, 1};
      vecs[12] = '{1, 11,0, 12, 1, 0, 1, 0, 32'hc,    32'h0,   0, 0, 1, 0, 0, 1, 32'h3,   32'h4,  0, 0, 11, 1};
      vecs[13] = '{1, 11,0, 12, 1, 0, 1, 0, 32'hc,    32'h0,   0, 0, 0, 1, 1, 1, 32'hc,   32'h0,  1, 0, 12, 1};

      // Reset with a valid instruction presented.
      reset = 1'b0;
      wb_rd = 5'd7; wb_reg_write = 1'b1; wb_data = 32'h0bad;
      drive(vecs[0]);
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset stall_cnt", {28'd0, stall_cnt}, 32'd0);
      chk("reset fwd", {28'd0, out_fwd_a, out_fwd_b}, 32'd0);
      chk("reset op1", out_op1, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_vld});
         chk($sformatf("v%0d stall_cnt", i), {28'd0, stall_cnt}, {28'd0, vecs[i].e_cnt});
         if (vecs[i].e_vld) begin
            chk($sformatf("v%0d op1", i), out_op1, vecs[i].e_op1);
            chk($sformatf("v%0d op2", i), out_op2, vecs[i].e_op2);
            chk($sformatf("v%0d fwd_a", i), {30'd0, out_fwd_a}, {30'd0, vecs[i].e_fa});
            chk($sformatf("v%0d fwd_b", i), {30'd0, out_fwd_b}, {30'd0, vecs[i].e_fb});
            chk($sformatf("v%0d rd", i), {27'd0, out_rd}, {27'd0, vecs[i].e_rd});
         end
      end

      // Repeated lw x5,0(x5): captures, then stalls behind itself, alternately.
      ld = '{1, 5, 0, 5, 1, 0, 1, 1, 32'h200, 32'h0, 0, 0, 0, 1,
             0, 0, 32'h0, 32'h0, 0, 0, 0, 0};
      cnt_exp = 4'd1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         drive(ld);
         #1;
         chk($sformatf("sat c%0d in_ready", i), {31'd0, in_ready}, {31'd0, (i % 2) == 0});
         @(posedge clk);
         #1;
         if ((i % 2) == 1 && cnt_exp != 4'hf) cnt_exp = cnt_exp + 4'd1;
         chk($sformatf("sat c%0d out_valid", i), {31'd0, out_valid}, {31'd0, (i % 2) == 0});
         if (i == 9 || i == 29 || i == 49)
            chk($sformatf("sat c%0d stall_cnt", i), {28'd0, stall_cnt}, {28'd0, cnt_exp});
      end

      // Capture once more, then reset between edges.
      @(negedge clk);
      drive(ld);
      @(posedge clk);
      #1;
      chk("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("async reset stall_cnt", {28'd0, stall_cnt}, 32'd0);
      chk("async reset rd", {27'd0, out_rd}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
